// File: rtl/riscv_pkg.sv
// Shared encodings for the 32-bit RISC-V core pipeline.
// Contents:
//   ALU_*        ALU operation select codes
//   RES_*        writeback result-source select codes
//   ex_ctrl_t    control bundle carried through the ID/EX register
//   CTRL_BUBBLE  control value loaded for a pipeline bubble
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic       alu_src;
    } ex_ctrl_t;

    // A bubble must not write anything or redirect the PC; the ALU op is ADD.
    localparam ex_ctrl_t CTRL_BUBBLE = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        branch:      1'b0,
        jump:        1'b0,
        result_src:  RES_ALU,
        alu_control: ALU_ADD,
        alu_src:     1'b0
    };

endpackage

// File: rtl/id_ex_operand_stage_fwd_sel.sv
// fwd_sel: per-operand forwarding comparator/mux.
// Picks the youngest in-flight producer of register rs (MEM before WB),
// otherwise the value read from the register file. x0 is never forwarded.
// Build option: ID_EX_FWD_EN defined enables forwarding; when undefined the
// block is a pass-through of reg_val and the M/W inputs are ignored.
// Ports:
//   rs, reg_val                         operand register address and RF value
//   reg_write_m, rd_m, alu_result_m     MEM-stage producer
//   reg_write_w, rd_w, result_w         WB-stage producer
//   operand_c                           selected operand (combinational)
module fwd_sel #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_val,
    input  logic              reg_write_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [XLEN-1:0]   result_w,
    output logic [XLEN-1:0]   operand_c
);

`ifdef ID_EX_FWD_EN
    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs);

    // MEM holds the younger result, so it is checked first.
    always_comb begin
        operand_c = reg_val;
        if (hit_m) begin
            operand_c = alu_result_m;
        end else if (hit_w) begin
            operand_c = result_w;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rs, reg_write_m, rd_m, alu_result_m,
                          reg_write_w, rd_w, result_w};

    always_comb begin
        operand_c = reg_val;
    end
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register plus ALU operand selection.
// Captures decoded operands/control, forwards from MEM/WB (build option
// ID_EX_FWD_EN), and drives srcA/srcB/ALU_control into the ALU.
// Register update priority per edge: rst > flush_e > stall_e > load.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_e, flush_e         hold / insert bubble
//   *_d                      decode-stage operands, addresses and control
//   *_m, *_w                 MEM/WB forwarding sources
//   srcA, srcB, ALU_control  ALU inputs (srcA/srcB combinational)
//   write_data_e             forwarded rs2 value for stores (combinational)
//   *_e, valid_e             registered stage contents
module id_ex_operand_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_ext_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   pc_plus4_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [2:0]        alu_control_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic              branch_d,
    input  logic              jump_d,
    input  logic [1:0]        result_src_d,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [XLEN-1:0]   result_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    output logic [XLEN-1:0]   srcA,
    output logic [XLEN-1:0]   srcB,
    output logic [2:0]        ALU_control,
    output logic [XLEN-1:0]   write_data_e,
    output logic [XLEN-1:0]   imm_ext_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   pc_plus4_e,
    output logic [REG_AW-1:0] rs1_e,
    output logic [REG_AW-1:0] rs2_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              branch_e,
    output logic              jump_e,
    output logic [1:0]        result_src_e,
    output logic              valid_e
);

    logic [XLEN-1:0] rd1_e;
    logic [XLEN-1:0] rd2_e;
    ex_ctrl_t        ctrl_e;
    ex_ctrl_t        ctrl_d;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign ctrl_d = '{
        reg_write:   reg_write_d,
        mem_write:   mem_write_d,
        branch:      branch_d,
        jump:        jump_d,
        result_src:  result_src_d,
        alu_control: alu_control_d,
        alu_src:     alu_src_d
    };

    // Stage register; a bubble clears data/address fields as well as control.
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_e     <= CTRL_BUBBLE;
            valid_e    <= 1'b0;
        end else if (!stall_e) begin
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            ctrl_e     <= ctrl_d;
            valid_e    <= 1'b1;
        end
    end

    // Forwarding stays live during a stall so operands track advancing M/W.
    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .rs           (rs1_e),
        .reg_val      (rd1_e),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .alu_result_m (alu_result_m),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .operand_c    (fwd_a)
    );

    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .rs           (rs2_e),
        .reg_val      (rd2_e),
        .reg_write_m  (reg_write_m),
        .rd_m         (rd_m),
        .alu_result_m (alu_result_m),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .result_w     (result_w),
        .operand_c    (fwd_b)
    );

    assign srcA         = fwd_a;
    assign srcB         = ctrl_e.alu_src ? imm_ext_e : fwd_b;
    // Store data is always the forwarded rs2 value, even for immediate ops.
    assign write_data_e = fwd_b;

    assign ALU_control  = ctrl_e.alu_control;
    assign reg_write_e  = ctrl_e.reg_write;
    assign mem_write_e  = ctrl_e.mem_write;
    assign branch_e     = ctrl_e.branch;
    assign jump_e       = ctrl_e.jump;
    assign result_src_e = ctrl_e.result_src;

endmodule
